// File: rtl/alu_pkg.sv
// ALU opcode constants and the ID/EX bubble encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'd1,
    ALU_XOR = 4'd2,
    ALU_SLL = 4'd3,
    ALU_ADD = 4'd4,
    ALU_SUB = 4'd5,
    ALU_MUL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_OR  = 4'd8
  } alu_op_e;

  // Registered control bits of the ID/EX stage.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } id_ex_ctrl_t;

  // A bubble is an inert instruction: no side effects, and the ALU is
  // given a defined opcode so it never sees garbage.
  localparam id_ex_ctrl_t CTRL_BUBBLE   = '0;
  localparam logic [3:0]  ALU_OP_BUBBLE = ALU_ADD;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID inputs, write-back forwarding ports and EX outputs.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int CNTW = 16
);

  logic            stall_i;
  logic            flush_i;
  logic            valid_i;
  logic [RAW-1:0]  rs1_addr_i;
  logic [RAW-1:0]  rs2_addr_i;
  logic [RAW-1:0]  rd_addr_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [XLEN-1:0] imm_i;
  logic [3:0]      alu_ctrl_i;
  logic            alu_src_i;
  logic            reg_write_i;
  logic            mem_read_i;
  logic            mem_write_i;
  logic            mem_to_reg_i;
  logic            exmem_reg_write_i;
  logic [RAW-1:0]  exmem_rd_i;
  logic [XLEN-1:0] exmem_data_i;
  logic            memwb_reg_write_i;
  logic [RAW-1:0]  memwb_rd_i;
  logic [XLEN-1:0] memwb_data_i;

  logic            hazard_o;
  logic [XLEN-1:0] alu_data1_o;
  logic [XLEN-1:0] alu_data2_o;
  logic [3:0]      alu_ctrl_o;
  logic [XLEN-1:0] store_data_o;
  logic [RAW-1:0]  rd_addr_o;
  logic            valid_o;
  logic            reg_write_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            mem_to_reg_o;
  logic [CNTW-1:0] bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
           rs1_data_i, rs2_data_i, imm_i, alu_ctrl_i, alu_src_i,
           reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i,
           exmem_reg_write_i, exmem_rd_i, exmem_data_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
    input  hazard_o, alu_data1_o, alu_data2_o, alu_ctrl_o, store_data_o,
           rd_addr_o, valid_o, reg_write_o, mem_read_o, mem_write_o,
           mem_to_reg_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
           rs1_data_i, rs2_data_i, imm_i, alu_ctrl_i, alu_src_i,
           reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i,
           exmem_reg_write_i, exmem_rd_i, exmem_data_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
    output hazard_o, alu_data1_o, alu_data2_o, alu_ctrl_o, store_data_o,
           rd_addr_o, valid_o, reg_write_o, mem_read_o, mem_write_o,
           mem_to_reg_o, bubble_cnt_o
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source-register forwarding select: EX/MEM beats MEM/WB, x0 never forwarded.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic [RAW-1:0]  addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exmem_reg_write,
  input  logic [RAW-1:0]  exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_reg_write,
  input  logic [RAW-1:0]  memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] data
);

  // Priority select of the freshest in-flight value for this register.
  always_comb begin
    data = reg_data;
    if (addr != '0) begin
      if (exmem_reg_write && (exmem_rd == addr)) begin
        data = exmem_data;
      end else if (memwb_reg_write && (memwb_rd == addr)) begin
        data = memwb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard
// detection and a saturating inserted-bubble counter.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int CNTW = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave bus
);

  id_ex_ctrl_t     ctrl_q;
  logic [RAW-1:0]  rs1_q;
  logic [RAW-1:0]  rs2_q;
  logic [RAW-1:0]  rd_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [3:0]      alu_ctrl_q;
  logic [CNTW-1:0] bubble_cnt_q;

  logic            hazard;
  logic            load_bubble;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // Load-use: the registered load's result is not ready for the ID
  // instruction; suppressed while frozen since nothing advances anyway.
  assign hazard = ~bus.stall_i & ctrl_q.valid & ctrl_q.mem_read & (rd_q != '0) &
                  bus.valid_i &
                  ((bus.rs1_addr_i == rd_q) | (bus.rs2_addr_i == rd_q));

  // Flush and hazard together still count as a single bubble.
  assign load_bubble = bus.flush_i | hazard;

  // Pipeline register and bubble counter update, reset > stall > bubble > load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q       <= CTRL_BUBBLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      alu_ctrl_q   <= ALU_OP_BUBBLE;
      bubble_cnt_q <= '0;
    end else if (!bus.stall_i) begin
      if (load_bubble) begin
        ctrl_q     <= CTRL_BUBBLE;
        rs1_q      <= '0;
        rs2_q      <= '0;
        rd_q       <= '0;
        rs1_data_q <= '0;
        rs2_data_q <= '0;
        imm_q      <= '0;
        alu_ctrl_q <= ALU_OP_BUBBLE;
        if (bubble_cnt_q != '1) begin
          bubble_cnt_q <= bubble_cnt_q + CNTW'(1);
        end
      end else begin
        ctrl_q.valid      <= bus.valid_i;
        ctrl_q.reg_write  <= bus.reg_write_i;
        ctrl_q.mem_read   <= bus.mem_read_i;
        ctrl_q.mem_write  <= bus.mem_write_i;
        ctrl_q.mem_to_reg <= bus.mem_to_reg_i;
        ctrl_q.alu_src    <= bus.alu_src_i;
        rs1_q             <= bus.rs1_addr_i;
        rs2_q             <= bus.rs2_addr_i;
        rd_q              <= bus.rd_addr_i;
        rs1_data_q        <= bus.rs1_data_i;
        rs2_data_q        <= bus.rs2_data_i;
        imm_q             <= bus.imm_i;
        alu_ctrl_q        <= bus.alu_ctrl_i;
      end
    end
  end

  fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
    .addr            (rs1_q),
    .reg_data        (rs1_data_q),
    .exmem_reg_write (bus.exmem_reg_write_i),
    .exmem_rd        (bus.exmem_rd_i),
    .exmem_data      (bus.exmem_data_i),
    .memwb_reg_write (bus.memwb_reg_write_i),
    .memwb_rd        (bus.memwb_rd_i),
    .memwb_data      (bus.memwb_data_i),
    .data            (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
    .addr            (rs2_q),
    .reg_data        (rs2_data_q),
    .exmem_reg_write (bus.exmem_reg_write_i),
    .exmem_rd        (bus.exmem_rd_i),
    .exmem_data      (bus.exmem_data_i),
    .memwb_reg_write (bus.memwb_reg_write_i),
    .memwb_rd        (bus.memwb_rd_i),
    .memwb_data      (bus.memwb_data_i),
    .data            (rs2_fwd)
  );

  assign bus.hazard_o     = hazard;
  assign bus.alu_data1_o  = rs1_fwd;
  assign bus.alu_data2_o  = ctrl_q.alu_src ? imm_q : rs2_fwd;
  assign bus.store_data_o = rs2_fwd;
  assign bus.alu_ctrl_o   = alu_ctrl_q;
  assign bus.rd_addr_o    = rd_q;
  assign bus.valid_o      = ctrl_q.valid;
  assign bus.reg_write_o  = ctrl_q.reg_write;
  assign bus.mem_read_o   = ctrl_q.mem_read;
  assign bus.mem_write_o  = ctrl_q.mem_write;
  assign bus.mem_to_reg_o = ctrl_q.mem_to_reg;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expectations are queued as stimulus
// is applied and popped against the DUT once the result is due.
module tb_id_ex_stage;
  import alu_pkg::*;

  localparam int S_D1 = 0, S_D2 = 1, S_CTRL = 2, S_STORE = 3, S_RD = 4,
                 S_VALID = 5, S_RW = 6, S_MR = 7, S_MW = 8, S_M2R = 9,
                 S_CNT = 10, S_HAZ = 11;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .RAW(5), .CNTW(16)) bus ();

  id_ex_stage #(.XLEN(32), .RAW(5), .CNTW(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_D1:    return bus.alu_data1_o;
      S_D2:    return bus.alu_data2_o;
      S_CTRL:  return 32'(bus.alu_ctrl_o);
      S_STORE: return bus.store_data_o;
      S_RD:    return 32'(bus.rd_addr_o);
      S_VALID: return 32'(bus.valid_o);
      S_RW:    return 32'(bus.reg_write_o);
      S_MR:    return 32'(bus.mem_read_o);
      S_MW:    return 32'(bus.mem_write_o);
      S_M2R:   return 32'(bus.mem_to_reg_o);
      S_CNT:   return 32'(bus.bubble_cnt_o);
      default: return 32'(bus.hazard_o);
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [3:0] op, input logic src,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
    bus.valid_i      = v;
    bus.rs1_addr_i   = rs1;
    bus.rs2_addr_i   = rs2;
    bus.rd_addr_i    = rd;
    bus.rs1_data_i   = d1;
    bus.rs2_data_i   = d2;
    bus.imm_i        = imm;
    bus.alu_ctrl_i   = op;
    bus.alu_src_i    = src;
    bus.reg_write_i  = rw;
    bus.mem_read_i   = mr;
    bus.mem_write_i  = mw;
    bus.mem_to_reg_i = m2r;
  endtask

  task automatic drive_wb(input logic erw, input logic [4:0] erd, input logic [31:0] ed,
                          input logic mrw, input logic [4:0] mrd, input logic [31:0] md);
    bus.exmem_reg_write_i = erw;
    bus.exmem_rd_i        = erd;
    bus.exmem_data_i      = ed;
    bus.memwb_reg_write_i = mrw;
    bus.memwb_rd_i        = mrd;
    bus.memwb_data_i      = md;
  endtask

  task automatic push_bubble(input string tag);
    push({tag, "_valid"}, S_VALID, 32'd0);
    push({tag, "_ctrl"}, S_CTRL, 32'd4);
    push({tag, "_rd"}, S_RD, 32'd0);
    push({tag, "_d1"}, S_D1, 32'd0);
    push({tag, "_rw"}, S_RW, 32'd0);
    push({tag, "_mr"}, S_MR, 32'd0);
  endtask

  task automatic bubble_count();
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // reset state
    @(posedge clk);
    push("rst_d1", S_D1, 32'd0);
    push("rst_d2", S_D2, 32'd0);
    push("rst_ctrl", S_CTRL, 32'd4);
    push("rst_store", S_STORE, 32'd0);
    push("rst_rd", S_RD, 32'd0);
    push("rst_valid", S_VALID, 32'd0);
    push("rst_rw", S_RW, 32'd0);
    push("rst_mr", S_MR, 32'd0);
    push("rst_mw", S_MW, 32'd0);
    push("rst_m2r", S_M2R, 32'd0);
    push("rst_cnt", S_CNT, 32'd0);
    push("rst_haz", S_HAZ, 32'd0);
    step();

    // plain add load
    rst = 1'b0;
    drive_id(1'b1, 5'd5, 5'd6, 5'd1, 32'd10, 32'd20, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push("add_d1", S_D1, 32'd10);
    push("add_d2", S_D2, 32'd20);
    push("add_ctrl", S_CTRL, 32'd4);
    push("add_store", S_STORE, 32'd20);
    push("add_rd", S_RD, 32'd1);
    push("add_valid", S_VALID, 32'd1);
    push("add_rw", S_RW, 32'd1);
    step();

    // forwarding priority on rs1=3
    drive_id(1'b1, 5'd3, 5'd4, 5'd2, 32'h11, 32'h22, 32'd0, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_wb(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    push("fwd_exmem", S_D1, 32'hAA);
    push("fwd_rs2_none", S_D2, 32'h22);
    push("fwd_ctrl", S_CTRL, 32'd5);
    step();
    bus.exmem_reg_write_i = 1'b0;
    push("fwd_memwb", S_D1, 32'hBB);
    settle();
    drive_wb(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    push("fwd_x0_reg", S_D1, 32'h11);
    settle();
    drive_wb(1'b1, 5'd4, 32'hCC, 1'b1, 5'd4, 32'hDD);
    push("fwd_rs2_exmem", S_STORE, 32'hCC);
    push("fwd_rs2_d2", S_D2, 32'hCC);
    settle();
    drive_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // load-use hazard
    drive_id(1'b1, 5'd1, 5'd2, 5'd7, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    push("ld_mr", S_MR, 32'd1);
    push("ld_m2r", S_M2R, 32'd1);
    push("ld_rd", S_RD, 32'd7);
    step();
    drive_id(1'b1, 5'd9, 5'd7, 5'd8, 32'h5, 32'h6, 32'd0, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push("lu_haz", S_HAZ, 32'd1);
    settle();
    bubble_count();
    push_bubble("lu_bub");
    push("lu_cnt", S_CNT, 32'(exp_cnt));
    push("lu_haz_clr", S_HAZ, 32'd0);
    step();
    push("lu_reload_valid", S_VALID, 32'd1);
    push("lu_reload_ctrl", S_CTRL, 32'd5);
    push("lu_reload_rd", S_RD, 32'd8);
    push("lu_reload_d1", S_D1, 32'h5);
    step();

    // flush under stall: held, then bubble once stall releases
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    drive_id(1'b1, 5'd1, 5'd2, 5'd12, 32'h9, 32'h9, 32'd0, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push("stf_valid", S_VALID, 32'd1);
    push("stf_ctrl", S_CTRL, 32'd5);
    push("stf_rd", S_RD, 32'd8);
    push("stf_cnt", S_CNT, 32'(exp_cnt));
    step();
    bus.stall_i = 1'b0;
    bubble_count();
    push_bubble("fl_bub");
    push("fl_cnt", S_CNT, 32'(exp_cnt));
    step();
    bus.flush_i = 1'b0;

    // hazard masked by stall, then flush+hazard counts one bubble
    drive_id(1'b1, 5'd1, 5'd2, 5'd7, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    drive_id(1'b1, 5'd7, 5'd3, 5'd9, 32'h1, 32'h2, 32'd0, ALU_XOR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.stall_i = 1'b1;
    push("haz_stall", S_HAZ, 32'd0);
    settle();
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b1;
    push("fh_haz", S_HAZ, 32'd1);
    settle();
    bubble_count();
    push_bubble("fh_bub");
    push("fh_cnt", S_CNT, 32'(exp_cnt));
    step();
    bus.flush_i = 1'b0;

    // immediate operand and forwarded store data
    drive_id(1'b1, 5'd1, 5'd6, 5'd10, 32'd3, 32'h55, 32'hFFFFFFFC, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_wb(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h1234);
    push("imm_d2", S_D2, 32'hFFFFFFFC);
    push("imm_store", S_STORE, 32'h1234);
    push("imm_d1", S_D1, 32'd3);
    push("imm_mw", S_MW, 32'd1);
    step();
    drive_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // reset while stalled clears state
    bus.stall_i = 1'b1;
    rst = 1'b1;
    exp_cnt = 16'd0;
    push("rstst_valid", S_VALID, 32'd0);
    push("rstst_ctrl", S_CTRL, 32'd4);
    push("rstst_d2", S_D2, 32'd0);
    push("rstst_cnt", S_CNT, 32'd0);
    step();
    rst = 1'b0;
    bus.stall_i = 1'b0;

    // counter saturation
    bus.flush_i = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
      bubble_count();
    end
    #1;
    push("sat_edge", S_CNT, 32'(exp_cnt));
    drain();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      bubble_count();
    end
    #1;
    push("sat_hold", S_CNT, 32'h0000FFFF);
    push("sat_model", S_CNT, 32'(exp_cnt));
    drain();
    bus.flush_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand selection. It sits directly upstream of the ALU: it captures decoded instructions from ID and drives the ALU's `data1_i`, `data2_i` and `ALUCtrl_i`. It also forwards results from EX/MEM and MEM/WB, and detects load-use hazards so it can insert bubbles. It keeps a saturating bubble counter for performance monitoring.

## Interface
- `XLEN`, 32, datapath width
- `RAW`, 5, register address width
- `CNTW`, 16, bubble counter width

- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `stall_i`  in  1  global freeze; hold all state
- `flush_i`  in  1  branch flush; load a bubble
- `valid_i`  in  1  ID holds a real instruction
- `rs1_addr_i`, `rs2_addr_i`, `rd_addr_i`  in  RAW  ID register addresses
- `rs1_data_i`, `rs2_data_i`, `imm_i`  in  XLEN  register-file reads and sign-extended immediate
- `alu_ctrl_i`  in  4  ALU opcode
- `alu_src_i`  in  1  1 = immediate as operand 2
- `reg_write_i`, `mem_read_i`, `mem_write_i`, `mem_to_reg_i`  in  1  control bits
- `exmem_reg_write_i`  in  1  EX/MEM write-back enable
- `exmem_rd_i`  in  RAW  EX/MEM destination
- `exmem_data_i`  in  XLEN  EX/MEM result
- `memwb_reg_write_i`  in  1  MEM/WB write-back enable
- `memwb_rd_i`  in  RAW  MEM/WB destination
- `memwb_data_i`  in  XLEN  MEM/WB result
- `hazard_o`  out  1  load-use stall request to IF/ID and PC
- `alu_data1_o`, `alu_data2_o`  out  XLEN  ALU operands
- `alu_ctrl_o`  out  4  ALU opcode
- `store_data_o`  out  XLEN  forwarded rs2 value for stores
- `rd_addr_o`  out  RAW  registered destination
- `valid_o`, `reg_write_o`, `mem_read_o`, `mem_write_o`, `mem_to_reg_o`  out  1  registered controls
- `bubble_cnt_o`  out  CNTW  inserted-bubble count, saturating

## Operation
- **Register update priority** (evaluated each rising edge): `rst_i` > `stall_i` (hold) > `flush_i` (bubble) > `hazard_o` (bubble) > load from ID.
- **Bubble**:
  - `valid`, `reg_write`, `mem_read`, `mem_write` and `mem_to_reg` = 0.
  - `rd` and the register addresses = 0.
  - Data fields = 0.
  - ALU opcode = `ALU_ADD` (4), so the ALU never sees an undefined opcode.
- **Hazard detection**:
  - `hazard_o` = `valid_q & mem_read_q & (rd_q != 0) & valid_i & (rs1_addr_i == rd_q | rs2_addr_i == rd_q)`.
  - It is combinational.
  - It is forced to 0 while `stall_i` is high.
- **Forwarding**, applied per source register to the registered address `rsN_q`:
  1. If `exmem_reg_write_i` and `exmem_rd_i == rsN_q != 0`, select `exmem_data_i`.
  2. Else if `memwb_reg_write_i` and `memwb_rd_i == rsN_q != 0`, select `memwb_data_i`.
  3. Else select the registered `rsN_data_q`.
  - EX/MEM always wins over MEM/WB. x0 is never forwarded.
- **Operand outputs**:
  - `alu_data1_o` = forwarded rs1.
  - `store_data_o` = forwarded rs2.
  - `alu_data2_o` = `imm_q` if `alu_src_q`, else forwarded rs2.
- **Bubble counter**:
  - Increments on each edge where a bubble is loaded because of a flush or a hazard.
  - Saturates at all ones.
  - Holds during `stall_i`.
  - Returns to 0 on reset.

## Timing
- ID-to-output latency is one cycle. The forwarding muxes are combinational from registered fields plus the live EX/MEM and MEM/WB inputs.
- `hazard_o` is valid in the same cycle as the ID inputs. Upstream must hold IF/ID and the PC while it is high. It deasserts the cycle after the bubble is loaded.
- Reset values: every output is 0, except `alu_ctrl_o` = 4.
- Reset mid-stall clears state in the same edge.
- Flush and hazard in the same cycle count one bubble.
- Stall and flush together hold state; the flush is lost, so upstream must keep `flush_i` asserted.

## Structure
- Package `alu_pkg` holds the opcode constants:
  - `ALU_AND`=1, `ALU_XOR`=2, `ALU_SLL`=3, `ALU_ADD`=4
  - `ALU_SUB`=5, `ALU_MUL`=6, `ALU_SRA`=7, `ALU_OR`=8
- The bubble encoding also lives in `alu_pkg`. The ALU imports the same package.
- One sub-module, `fwd_mux`, is instantiated twice (rs1 and rs2). It takes an address, the registered data and both write-back ports, and returns the selected value.

## Test plan
- **Reset and load.** Assert reset, then load `add` with rs1=5, rs2=6, data 10 and 20.
  - During reset: all outputs 0 and `alu_ctrl_o`=4.
  - Next cycle: `alu_data1_o`=10, `alu_data2_o`=20.
- **Forwarding priority.** Registered rs1=3; EX/MEM rd=3 with data 0xAA; MEM/WB rd=3 with data 0xBB.
  - Expect `alu_data1_o`=0xAA.
  - With EX/MEM `reg_write`=0, expect 0xBB.
  - With rd=0 on both ports, expect the registered value.
- **Load-use hazard.** Registered load has rd=7; ID presents rs2=7 with `valid_i`=1.
  - Expect `hazard_o`=1 in that cycle.
  - Next cycle: `valid_o`=0, `alu_ctrl_o`=4, `bubble_cnt_o`=1, `hazard_o`=0.
- **Flush under stall.** Assert `stall_i` and `flush_i` together.
  - Expect all outputs unchanged and the counter unchanged.
  - Release `stall_i` with `flush_i` still high: expect a bubble and the counter +1.
- **Immediate and store paths.** `alu_src_i`=1 with `imm_i`=-4 (0xFFFFFFFC).
  - Expect `alu_data2_o`=0xFFFFFFFC.
  - `store_data_o` = forwarded rs2 (MEM/WB data 0x1234 when `memwb_rd_i` matches).
- **Counter saturation.** Force 65,540 bubbles with CNTW=16.
  - Expect `bubble_cnt_o` to stay at 0xFFFF.
